ss_scan_mux: RTL and testbench



---
 rtl/ss_pkg.sv | 59 +++++
 rtl/ss_scan_timer.sv | 60 ++++++
 rtl/ss_scan_mux.sv | 143 ++++++++++++++
 tb/tb_ss_scan_mux.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/ss_pkg.sv
// Shared definitions for the seven-segment scan driver: segment encodings
// (gfedcba, 1 = lit) and the output polarity helper.
package ss_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b000_0000;

    localparam logic [6:0] HEX_0 = 7'h3F;
    localparam logic [6:0] HEX_1 = 7'h06;
    localparam logic [6:0] HEX_2 = 7'h5B;
    localparam logic [6:0] HEX_3 = 7'h4F;
    localparam logic [6:0] HEX_4 = 7'h66;
    localparam logic [6:0] HEX_5 = 7'h6D;
    localparam logic [6:0] HEX_6 = 7'h7D;
    localparam logic [6:0] HEX_7 = 7'h07;
    localparam logic [6:0] HEX_8 = 7'h7F;
    localparam logic [6:0] HEX_9 = 7'h6F;
    localparam logic [6:0] HEX_A = 7'h77;
    localparam logic [6:0] HEX_B = 7'h7C;
    localparam logic [6:0] HEX_C = 7'h39;
    localparam logic [6:0] HEX_D = 7'h5E;
    localparam logic [6:0] HEX_E = 7'h79;
    localparam logic [6:0] HEX_F = 7'h71;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        logic [6:0] r;
        case (h)
            4'h0:    r = HEX_0;
            4'h1:    r = HEX_1;
            4'h2:    r = HEX_2;
            4'h3:    r = HEX_3;
            4'h4:    r = HEX_4;
            4'h5:    r = HEX_5;
            4'h6:    r = HEX_6;
            4'h7:    r = HEX_7;
            4'h8:    r = HEX_8;
            4'h9:    r = HEX_9;
            4'hA:    r = HEX_A;
            4'hB:    r = HEX_B;
            4'hC:    r = HEX_C;
            4'hD:    r = HEX_D;
            4'hE:    r = HEX_E;
            4'hF:    r = HEX_F;
            default: r = SEG_BLANK;
        endcase
        return r;
    endfunction

    // Maps logical (1 = on) levels to the physical pin level.
    function automatic logic [7:0] apply_pol8(input logic [7:0] v, input logic active_low);
        logic [7:0] r;
        if (active_low) begin
            r = ~v;
        end else begin
            r = v;
        end
        return r;
    endfunction

endpackage

// File: rtl/ss_scan_timer.sv
// Scan timing for the segment driver: slot prescaler, digit index counting
// down from the leftmost digit, and the free-running blink counter.
module ss_scan_timer
    import ss_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_BITS  = 15,
    parameter int BLINK_BITS = 24,
    parameter int IDX_W      = $clog2(NUM_DIGITS)
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [IDX_W-1:0] idx,
    output logic [3:0]       sub,
    output logic             blink_off,
    output logic             slot_end
);

    logic [SCAN_BITS-1:0]  presc_q, presc_d;
    logic [BLINK_BITS-1:0] blink_q, blink_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  slot_end_s;

    assign slot_end_s = &presc_q;

    // Next-state for the counters; index wraps explicitly so non-power-of-2 counts work.
    always_comb begin
        presc_d = presc_q + SCAN_BITS'(1);
        blink_d = blink_q + BLINK_BITS'(1);
        idx_d   = idx_q;
        if (slot_end_s) begin
            if (idx_q == IDX_W'(0)) begin
                idx_d = IDX_W'(NUM_DIGITS - 1);
            end else begin
                idx_d = idx_q - IDX_W'(1);
            end
        end else begin
            idx_d = idx_q;
        end
    end

    // Counter state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            blink_q <= '0;
            idx_q   <= IDX_W'(NUM_DIGITS - 1);
        end else begin
            presc_q <= presc_d;
            blink_q <= blink_d;
            idx_q   <= idx_d;
        end
    end

    assign idx       = idx_q;
    assign sub       = presc_q[SCAN_BITS-1 -: 4];
    assign blink_off = blink_q[BLINK_BITS-1];
    assign slot_end  = slot_end_s;

endmodule

// File: rtl/ss_scan_mux.sv
// N-digit multiplexed seven-segment driver with per-frame input snapshot,
// per-digit blank/blink, 16-level brightness and configurable pin polarity.
module ss_scan_mux
    import ss_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int SCAN_BITS      = 15,
    parameter int BLINK_BITS     = 24,
    parameter int AN_ACTIVE_LOW  = 1,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [7*NUM_DIGITS-1:0] seg_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   mask,
    input  logic [NUM_DIGITS-1:0]   blink,
    input  logic [3:0]              bright,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_tick
);

    localparam int   IDX_W   = $clog2(NUM_DIGITS);
    localparam logic AN_LOW  = (AN_ACTIVE_LOW != 0);
    localparam logic SEG_LOW = (SEG_ACTIVE_LOW != 0);
    localparam logic [NUM_DIGITS-1:0] AN_OFF  = AN_LOW ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};
    localparam logic [NUM_DIGITS-1:0] AN_ONE  = {{(NUM_DIGITS-1){1'b0}}, 1'b1};
    localparam logic [6:0]            SEG_OFF = SEG_LOW ? 7'h7F : 7'h00;

    logic [IDX_W-1:0] idx_s;
    logic [3:0]       sub_s;
    logic             blink_off_s;
    logic             slot_end_s;

    ss_scan_timer #(
        .NUM_DIGITS (NUM_DIGITS),
        .SCAN_BITS  (SCAN_BITS),
        .BLINK_BITS (BLINK_BITS),
        .IDX_W      (IDX_W)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .idx       (idx_s),
        .sub       (sub_s),
        .blink_off (blink_off_s),
        .slot_end  (slot_end_s)
    );

    logic [7*NUM_DIGITS-1:0] snap_seg_q, snap_seg_d;
    logic [NUM_DIGITS-1:0]   snap_dp_q, snap_dp_d;
    logic [NUM_DIGITS-1:0]   snap_mask_q, snap_mask_d;
    logic [NUM_DIGITS-1:0]   snap_blink_q, snap_blink_d;
    logic [3:0]              snap_bright_q, snap_bright_d;
    logic                    load_pending_q, load_pending_d;
    logic                    frame_tick_q, frame_tick_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;

    logic                    frame_start_s;
    logic [6:0]              seg_arr_s [NUM_DIGITS];
    logic [6:0]              cur_seg_s;
    logic                    lit_s;
    logic [NUM_DIGITS-1:0]   an_oh_s;
    logic [7:0]              segdp_pol_s;

    assign frame_start_s = (slot_end_s && (idx_s == IDX_W'(0))) || load_pending_q;

    // Snapshot capture: inputs are only sampled at a frame boundary to avoid tearing.
    always_comb begin
        load_pending_d = load_pending_q & ~frame_start_s;
        frame_tick_d   = frame_start_s;
        if (frame_start_s) begin
            snap_seg_d    = seg_in;
            snap_dp_d     = dp_in;
            snap_mask_d   = mask;
            snap_blink_d  = blink;
            snap_bright_d = bright;
        end else begin
            snap_seg_d    = snap_seg_q;
            snap_dp_d     = snap_dp_q;
            snap_mask_d   = snap_mask_q;
            snap_blink_d  = snap_blink_q;
            snap_bright_d = snap_bright_q;
        end
    end

    // Lit decision for the current digit and conversion to physical pin levels.
    always_comb begin
        for (int k = 0; k < NUM_DIGITS; k++) begin
            seg_arr_s[k] = snap_seg_q[7*k +: 7];
        end
        cur_seg_s = seg_arr_s[idx_s];
        lit_s = (sub_s <= snap_bright_q)
              && !snap_mask_q[idx_s]
              && !(snap_blink_q[idx_s] && blink_off_s);
        if (lit_s) begin
            an_oh_s     = AN_ONE << idx_s;
            segdp_pol_s = apply_pol8({cur_seg_s, snap_dp_q[idx_s]}, SEG_LOW);
        end else begin
            an_oh_s     = '0;
            segdp_pol_s = apply_pol8({SEG_BLANK, 1'b0}, SEG_LOW);
        end
        seg_d = segdp_pol_s[7:1];
        dp_d  = segdp_pol_s[0];
        an_d  = an_oh_s ^ {NUM_DIGITS{AN_LOW}};
    end

    // Snapshot, control and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_seg_q     <= '0;
            snap_dp_q      <= '0;
            snap_mask_q    <= {NUM_DIGITS{1'b1}};
            snap_blink_q   <= '0;
            snap_bright_q  <= 4'd0;
            load_pending_q <= 1'b1;
            frame_tick_q   <= 1'b0;
            seg_q          <= SEG_OFF;
            dp_q           <= SEG_LOW;
            an_q           <= AN_OFF;
        end else begin
            snap_seg_q     <= snap_seg_d;
            snap_dp_q      <= snap_dp_d;
            snap_mask_q    <= snap_mask_d;
            snap_blink_q   <= snap_blink_d;
            snap_bright_q  <= snap_bright_d;
            load_pending_q <= load_pending_d;
            frame_tick_q   <= frame_tick_d;
            seg_q          <= seg_d;
            dp_q           <= dp_d;
            an_q           <= an_d;
        end
    end

    assign seg        = seg_q;
    assign dp         = dp_q;
    assign an         = an_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_ss_scan_mux.sv
// Bench for ss_scan_mux (3 digits, 32-clock slots, 256-clock blink) against a
// cycle-count based reference model of the scan and snapshot rules.
module tb_ss_scan_mux;

    localparam int N = 3;
    localparam int S = 5;
    localparam int B = 8;
    localparam int SLOT = 1 << S;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [7*N-1:0] seg_in = '0;
    logic [N-1:0]  dp_in = '0;
    logic [N-1:0]  mask = '0;
    logic [N-1:0]  blink = '0;
    logic [3:0]    bright = 4'd0;
    logic [6:0]    seg;
    logic          dp;
    logic [N-1:0]  an;
    logic          frame_tick;

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;

    // Reference snapshot as the model believes the display currently holds it.
    logic [7*N-1:0] m_seg;
    logic [N-1:0]   m_dp, m_mask, m_blink;
    logic [3:0]     m_bright;

    always #5 clk = ~clk;

    ss_scan_mux #(
        .NUM_DIGITS     (N),
        .SCAN_BITS      (S),
        .BLINK_BITS     (B),
        .AN_ACTIVE_LOW  (1),
        .SEG_ACTIVE_LOW (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .seg_in     (seg_in),
        .dp_in      (dp_in),
        .mask       (mask),
        .blink      (blink),
        .bright     (bright),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .frame_tick (frame_tick)
    );

    task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s cyc=%0d observed={seg,dp,an,ft}=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        cyc      = 0;
        m_seg    = '0;
        m_dp     = '0;
        m_mask   = '1;
        m_blink  = '0;
        m_bright = 4'd0;
    endtask

    // One clock: predict outputs from elapsed cycles and the model snapshot, then compare.
    task automatic tick(input string tag);
        int p, d, sub;
        logic bo, lit, fs;
        logic [6:0] e_seg;
        logic e_dp;
        logic [N-1:0] e_an, one_hot;
        p   = cyc % SLOT;
        d   = (N - 1) - ((cyc / SLOT) % N);
        sub = p / 2;
        bo  = ((cyc / (1 << (B - 1))) % 2) == 1;
        lit = (sub <= int'(m_bright)) && !m_mask[d] && !(m_blink[d] && bo);
        fs  = (cyc == 0) || (p == SLOT - 1 && d == 0);
        one_hot = 3'b001 << d;
        e_an  = lit ? ~one_hot : 3'b111;
        e_seg = lit ? ~m_seg[d*7 +: 7] : 7'h7F;
        e_dp  = lit ? ~m_dp[d] : 1'b1;
        @(posedge clk);
        if (fs) begin
            m_seg    = seg_in;
            m_dp     = dp_in;
            m_mask   = mask;
            m_blink  = blink;
            m_bright = bright;
        end
        cyc++;
        #1;
        check(tag, {seg, dp, an, frame_tick}, {e_seg, e_dp, e_an, fs});
    endtask

    initial begin
        model_reset();
        seg_in = {7'h06, 7'h5B, 7'h4F};
        dp_in  = 3'b000;
        bright = 4'd15;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", {seg, dp, an, frame_tick}, {7'h7F, 1'b1, 3'b111, 1'b0});
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 300; i++) tick("full_bright");

        bright = 4'd3;
        dp_in  = 3'b101;
        for (int i = 0; i < 200; i++) tick("bright3");

        bright = 4'd15;
        mask   = 3'b010;
        for (int i = 0; i < 200; i++) tick("mask1");

        mask  = 3'b000;
        blink = 3'b001;
        for (int i = 0; i < 600; i++) tick("blink0");

        blink = 3'b000;
        for (int i = 0; i < 96 && (cyc % 96) != 40; i++) tick("to_mid");
        seg_in = {7'h3F, 7'h06, 7'h7D};
        for (int i = 0; i < 150; i++) tick("mid_change");

        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                seg_in = 21'($urandom);
                dp_in  = 3'($urandom);
                mask   = 3'($urandom);
                blink  = 3'($urandom);
                bright = 4'($urandom);
            end
            tick("random");
        end

        for (int i = 0; i < 45; i++) tick("pre_reset");
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", {seg, dp, an, frame_tick}, {7'h7F, 1'b1, 3'b111, 1'b0});
        @(negedge clk);
        check("reset_hold", {seg, dp, an, frame_tick}, {7'h7F, 1'b1, 3'b111, 1'b0});
        model_reset();
        seg_in = {7'h66, 7'h6D, 7'h07};
        dp_in  = 3'b100;
        mask   = 3'b000;
        blink  = 3'b000;
        bright = 4'd15;
        rst_n  = 1'b1;
        tick("post_reset_first");
        seg_in = {7'h71, 7'h79, 7'h5E};
        for (int i = 0; i < 300; i++) tick("post_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
